// File: rtl/wb_sysctl_if.sv
// Register-bus port of the system controller: one word-addressed access per
// cyc pulse, acknowledged one cycle later.
interface wb_sysctl_if #(
    parameter int DW = 32
);
    logic [2:0]      wb_addr;
    logic [DW-1:0]   wb_wdata;
    logic [DW/8-1:0] wb_wmsk;
    logic            wb_we;
    logic            wb_cyc;
    logic [DW-1:0]   wb_rdata;
    logic            wb_ack;

    modport master (
        output wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc,
        input  wb_rdata, wb_ack
    );

    modport slave (
        input  wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc,
        output wb_rdata, wb_ack
    );
endinterface

// File: rtl/wb_sysctl.sv
// System controller: delayed warm-boot sequencer, watchdog that forces a boot
// into a fallback image, free-running cycle counter and scratch registers.
//
//   state | meaning
//   IDLE  | no boot requested
//   ARMED | boot requested, delay counter running down
//   FIRE  | boot_now asserted; terminal until reset
module wb_sysctl #(
    parameter int               DW        = 32,
    parameter int               SEL_W     = 2,
    parameter int               WDT_W     = 24,
    parameter logic [SEL_W-1:0] WDT_SEL   = 2'b01,
    parameter int               N_SCRATCH = 2
) (
    input  logic             clk,
    input  logic             rst,
    wb_sysctl_if.slave       wb,
    output logic             boot_now,
    output logic [SEL_W-1:0] boot_sel,
    output logic             wdt_fired
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, FIRE = 2'd2} state_t;

    localparam logic [2:0]  A_BOOT   = 3'd0;
    localparam logic [2:0]  A_WCTRL  = 3'd1;
    localparam logic [2:0]  A_WRLD   = 3'd2;
    localparam logic [2:0]  A_KICK   = 3'd3;
    localparam logic [2:0]  A_CYC    = 3'd4;
    localparam logic [2:0]  A_SCR0   = 3'd5;
    localparam logic [2:0]  A_SCR1   = 3'd6;
    localparam logic [15:0] KICK_KEY = 16'h4B1C;

    state_t           state_q, state_d;
    logic             ack_q, ack_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       dly_q, dly_d;
    logic             fired_q, fired_d;
    logic             en_q, en_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic [WDT_W-1:0] reload_q, reload_d;
    logic [31:0]      cycles_q, cycles_d;
    logic [DW-1:0]    scratch_q [2];
    logic [DW-1:0]    scratch_d [2];

    logic          acc, wr, wr_boot, go, kick_ok, wdt_expire;
    logic [DW-1:0] rd_val;

    // Access strobe and the events it produces; a valid kick suppresses expiry.
    always_comb begin
        acc        = wb.wb_cyc & ~ack_q;
        wr         = acc & wb.wb_we;
        wr_boot    = wr && (wb.wb_addr == A_BOOT) && (state_q != FIRE);
        go         = wb.wb_wdata[2];
        kick_ok    = wr && (wb.wb_addr == A_KICK) && (wb.wb_wdata[15:0] == KICK_KEY);
        wdt_expire = en_q && (wdt_q == '0) && (state_q != FIRE) && !kick_ok;
    end

    // Boot FSM next state; watchdog expiry overrides anything software asks for.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wr_boot && go) state_d = ARMED;
            ARMED: begin
                if (wr_boot)               state_d = go ? ARMED : IDLE;
                else if (dly_q == 8'd0)    state_d = FIRE;
            end
            FIRE:    state_d = FIRE;
            default: state_d = IDLE;
        endcase
        if (wdt_expire) state_d = FIRE;
    end

    // Register-file writes, delay and watchdog counters.
    always_comb begin
        sel_d     = sel_q;
        dly_d     = dly_q;
        fired_d   = fired_q | wdt_expire;
        en_d      = en_q;
        reload_d  = reload_q;
        wdt_d     = wdt_q;
        cycles_d  = cycles_q + 32'd1;
        scratch_d = scratch_q;
        if (state_q == ARMED && dly_q != 8'd0) dly_d = dly_q - 8'd1;
        if (wr_boot) begin
            sel_d = wb.wb_wdata[SEL_W-1:0];
            if (go) dly_d = wb.wb_wdata[15:8];
        end
        if (wdt_expire) sel_d = WDT_SEL;
        if (wr && wb.wb_addr == A_WCTRL) en_d = wb.wb_wdata[0];
        if (wr && wb.wb_addr == A_WRLD) reload_d = wb.wb_wdata[WDT_W-1:0];
        if (en_q && state_q != FIRE && wdt_q != '0) wdt_d = wdt_q - WDT_W'(1);
        // Reload on a good kick or on the rising edge of enable.
        if (kick_ok || (wr && wb.wb_addr == A_WCTRL && wb.wb_wdata[0] && !en_q))
            wdt_d = reload_q;
        for (int i = 0; i < 2; i++) begin
            if (i < N_SCRATCH && wr && wb.wb_addr == (A_SCR0 + 3'(i))) begin
                for (int b = 0; b < DW/8; b++) begin
                    if (wb.wb_wmsk[b]) scratch_d[i][8*b +: 8] = wb.wb_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read mux; rdata is forced to zero outside the ack cycle.
    always_comb begin
        rd_val = '0;
        case (wb.wb_addr)
            A_BOOT: begin
                rd_val[SEL_W-1:0] = sel_q;
                rd_val[9:8]       = state_q;
            end
            A_WCTRL: rd_val[0]         = en_q;
            A_WRLD:  rd_val[WDT_W-1:0] = reload_q;
            A_CYC:   rd_val            = cycles_q;
            A_SCR0:  if (N_SCRATCH > 0) rd_val = scratch_q[0];
            A_SCR1:  if (N_SCRATCH > 1) rd_val = scratch_q[1];
            default: rd_val = '0;
        endcase
        ack_d   = acc;
        rdata_d = acc ? rd_val : '0;
    end

    // Outputs decoded from registered state.
    always_comb begin
        boot_now  = (state_q == FIRE);
        boot_sel  = sel_q;
        wdt_fired = fired_q;
    end

    assign wb.wb_ack   = ack_q;
    assign wb.wb_rdata = rdata_q;

    // Boot FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Bus, register-file and counter flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            sel_q    <= '0;
            dly_q    <= '0;
            fired_q  <= 1'b0;
            en_q     <= 1'b0;
            wdt_q    <= '0;
            reload_q <= '1;
            cycles_q <= '0;
            for (int i = 0; i < 2; i++) scratch_q[i] <= '0;
        end else begin
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            sel_q    <= sel_d;
            dly_q    <= dly_d;
            fired_q  <= fired_d;
            en_q     <= en_d;
            wdt_q    <= wdt_d;
            reload_q <= reload_d;
            cycles_q <= cycles_d;
            for (int i = 0; i < 2; i++) scratch_q[i] <= scratch_d[i];
        end
    end
endmodule

// File: tb/tb_wb_sysctl.sv
// Directed bench for wb_sysctl: boot sequencing, watchdog, counter, scratch.
module tb_wb_sysctl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       boot_now, wdt_fired;
    logic [1:0] boot_sel;
    logic       seen;
    int         n_cmp = 0;
    int         n_err = 0;

    wb_sysctl_if #(.DW(32)) bus ();

    wb_sysctl dut (
        .clk       (clk),
        .rst       (rst),
        .wb        (bus),
        .boot_now  (boot_now),
        .boot_sel  (boot_sel),
        .wdt_fired (wdt_fired)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns one cycle after the ack cycle.
    task automatic wb_xfer(input logic [2:0] a, input logic we, input logic [31:0] d,
                           input logic [3:0] m, output logic [31:0] rd);
        bus.wb_addr  = a;
        bus.wb_we    = we;
        bus.wb_wdata = d;
        bus.wb_wmsk  = m;
        bus.wb_cyc   = 1'b1;
        @(negedge clk);
        check_val("ack_hi", 32'(bus.wb_ack), 32'd1);
        rd = bus.wb_rdata;
        bus.wb_cyc = 1'b0;
        bus.wb_we  = 1'b0;
        @(negedge clk);
        check_val("ack_lo", 32'(bus.wb_ack), 32'd0);
        check_val("rdata_idle", bus.wb_rdata, 32'd0);
    endtask

    task automatic wb_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] rd;
        wb_xfer(a, 1'b1, d, m, rd);
    endtask

    task automatic wb_rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        wb_xfer(a, 1'b0, 32'd0, 4'd0, rd);
        check_val(tag, rd, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("rst_boot_now", 32'(boot_now), 32'd0);
        check_val("rst_boot_sel", 32'(boot_sel), 32'd0);
        check_val("rst_wdt_fired", 32'(wdt_fired), 32'd0);
        check_val("rst_ack", 32'(bus.wb_ack), 32'd0);
        rst = 1'b0;
    endtask

    task automatic expect_fire(input string tag, input logic [1:0] sel, input logic fired);
        check_val({tag, "_now"}, 32'(boot_now), 32'd1);
        check_val({tag, "_sel"}, 32'(boot_sel), 32'(sel));
        check_val({tag, "_wdt"}, 32'(wdt_fired), 32'(fired));
    endtask

    task automatic expect_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_val(tag, 32'(boot_now), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        bus.wb_addr  = 3'd0;
        bus.wb_wdata = 32'd0;
        bus.wb_wmsk  = 4'd0;
        bus.wb_we    = 1'b0;
        bus.wb_cyc   = 1'b0;
        idle(2);
        do_reset();
        wb_rd(3'd4, 32'd0, "cycles_rst");
        wb_rd(3'd4, 32'd2, "cycles_step");
        wb_rd(3'd2, 32'h00FF_FFFF, "reload_rst");
        wb_rd(3'd1, 32'd0, "wctrl_rst");
        wb_rd(3'd0, 32'd0, "boot_rst");
        wb_rd(3'd7, 32'd0, "reserved_rd");
        wb_rd(3'd5, 32'd0, "scr0_rst");

        wb_wr(3'd5, 32'hAABB_CCDD, 4'b0101);
        wb_rd(3'd5, 32'h00BB_00DD, "scr0_mask");
        wb_wr(3'd6, 32'h1234_5678, 4'hF);
        wb_rd(3'd6, 32'h1234_5678, "scr1_full");
        wb_wr(3'd6, 32'hFFFF_FFFF, 4'b1000);
        wb_rd(3'd6, 32'hFF34_5678, "scr1_byte3");
        wb_wr(3'd7, 32'hFFFF_FFFF, 4'hF);
        wb_rd(3'd7, 32'd0, "reserved_wr");

        // sel=2, go, delay=3: FIRE four cycles after the ack cycle.
        wb_wr(3'd0, 32'h0000_0306, 4'hF);
        expect_quiet("boot_delay3", 3);
        expect_fire("boot_delay3", 2'd2, 1'b0);
        wb_rd(3'd0, 32'h0000_0202, "fire_state");
        wb_wr(3'd0, 32'h0000_0007, 4'hF);
        wb_rd(3'd0, 32'h0000_0202, "fire_ignores_wr");
        do_reset();
        wb_rd(3'd4, 32'd0, "cycles_rst_fire");
        wb_rd(3'd0, 32'd0, "boot_rst_fire");

        // delay=0 fires on the cycle after the ack cycle.
        wb_wr(3'd0, 32'h0000_0004, 4'hF);
        expect_fire("boot_delay0", 2'd0, 1'b0);
        do_reset();

        // Re-arm while ARMED reloads the delay and re-latches sel.
        wb_wr(3'd0, 32'h0000_0306, 4'hF);
        wb_wr(3'd0, 32'h0000_0305, 4'hF);
        expect_quiet("rearm", 3);
        expect_fire("rearm", 2'd1, 1'b0);
        do_reset();

        // Cancel: go=0 while ARMED returns to IDLE keeping sel.
        wb_wr(3'd0, 32'h0000_1005, 4'hF);
        wb_rd(3'd0, 32'h0000_0101, "armed_state");
        idle(1);
        wb_wr(3'd0, 32'h0000_0001, 4'hF);
        wb_rd(3'd0, 32'h0000_0001, "cancel_state");
        seen = 1'b0;
        repeat (30) begin @(negedge clk); if (boot_now) seen = 1'b1; end
        check_val("cancel_no_boot", 32'(seen), 32'd0);

        // Reset while ARMED aborts the sequence.
        wb_wr(3'd0, 32'h0000_4006, 4'hF);
        idle(5);
        do_reset();
        wb_rd(3'd4, 32'd0, "cycles_rst_armed");
        wb_rd(3'd0, 32'd0, "boot_rst_armed");
        seen = 1'b0;
        repeat (80) begin @(negedge clk); if (boot_now) seen = 1'b1; end
        check_val("armed_rst_no_boot", 32'(seen), 32'd0);

        // Watchdog reload=5, no kick: FIRE six cycles after the enable ack.
        wb_wr(3'd2, 32'd5, 4'hF);
        wb_wr(3'd1, 32'd1, 4'hF);
        expect_quiet("wdt5", 5);
        expect_fire("wdt5", 2'd1, 1'b1);
        do_reset();

        // Valid kicks every 4 cycles hold off expiry; a bad key does not.
        wb_wr(3'd2, 32'd5, 4'hF);
        wb_wr(3'd1, 32'd1, 4'hF);
        for (int k = 0; k < 6; k++) begin
            wb_wr(3'd3, 32'h0000_4B1C, 4'hF);
            check_val("kick_hold", 32'(boot_now), 32'd0);
            idle(2);
        end
        wb_wr(3'd3, 32'h0000_1234, 4'hF);
        check_val("bad_kick_pre", 32'(boot_now), 32'd0);
        @(negedge clk);
        expect_fire("bad_kick", 2'd1, 1'b1);
        do_reset();

        // Reload of zero expires on the cycle after enable.
        wb_wr(3'd2, 32'd0, 4'hF);
        wb_wr(3'd1, 32'd1, 4'hF);
        expect_fire("reload0", 2'd1, 1'b1);
        do_reset();

        // A kick landing in the expiry cycle wins.
        wb_wr(3'd2, 32'd2, 4'hF);
        wb_wr(3'd1, 32'd1, 4'hF);
        idle(1);
        wb_wr(3'd3, 32'h0000_4B1C, 4'hF);
        expect_quiet("kick_wins", 2);
        expect_fire("kick_wins", 2'd1, 1'b1);
        do_reset();

        // A go write in the expiry cycle is overridden by the watchdog.
        wb_wr(3'd2, 32'd2, 4'hF);
        wb_wr(3'd1, 32'd1, 4'hF);
        idle(1);
        wb_wr(3'd0, 32'h0000_0506, 4'hF);
        expect_fire("go_vs_wdt", 2'd1, 1'b1);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
